// File: rtl/output_buffer.sv
// Packs 1-bit edge decisions MSB-first into WORD_BITS-wide words and emits
// each word with a sequential word address that wraps at endpixel or on img_done.
module output_buffer #(
    parameter int unsigned WORD_BITS  = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  edge_pixel,
    input  logic                  out_en,
    input  logic                  write_out_enable,
    input  logic [ADDR_WIDTH-1:0] endpixel,
    input  logic                  img_done,
    output logic [WORD_BITS-1:0]  out_pixel,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  out_empty,
    output logic                  out_full
);

    localparam int unsigned CW = $clog2(WORD_BITS + 1);

    logic [WORD_BITS-1:0]  sr;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] wr_ptr;

    logic                  write_accept;
    logic                  shift_accept;
    logic [CW-1:0]         pad;
    logic [WORD_BITS-1:0]  aligned;

    assign out_empty = (count == '0);
    assign out_full  = (count == CW'(WORD_BITS));

    always_comb begin
        write_accept = write_out_enable && (out_full || (img_done && !out_empty));
        shift_accept = out_en && (!out_full || write_accept);
        // Partial words are left-justified so the first pixel always lands in the MSB.
        pad          = CW'(WORD_BITS) - count;
        aligned      = sr << pad;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sr         <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            out_pixel  <= '0;
            write_addr <= '0;
        end else if (write_accept) begin
            out_pixel  <= aligned;
            write_addr <= wr_ptr;
            if (wr_ptr == endpixel || img_done) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            // A bit arriving with the write opens the next word.
            if (shift_accept) begin
                sr    <= WORD_BITS'(edge_pixel);
                count <= CW'(1);
            end else begin
                sr    <= '0;
                count <= '0;
            end
        end else if (shift_accept) begin
            sr    <= {sr[WORD_BITS-2:0], edge_pixel};
            count <= count + CW'(1);
        end
    end

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_output_buffer;

    localparam int unsigned WB = 32;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          edge_pixel = 1'b0;
    logic          out_en = 1'b0;
    logic          write_out_enable = 1'b0;
    logic [AW-1:0] endpixel = 32'd1000;
    logic          img_done = 1'b0;
    logic [WB-1:0] out_pixel;
    logic [AW-1:0] write_addr;
    logic          out_empty;
    logic          out_full;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit            mq[$];
    logic [AW-1:0] m_ptr = '0;
    logic [WB-1:0] m_pix = '0;
    logic [AW-1:0] m_addr = '0;

    output_buffer #(.WORD_BITS(WB), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .edge_pixel       (edge_pixel),
        .out_en           (out_en),
        .write_out_enable (write_out_enable),
        .endpixel         (endpixel),
        .img_done         (img_done),
        .out_pixel        (out_pixel),
        .write_addr       (write_addr),
        .out_empty        (out_empty),
        .out_full         (out_full)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [WB-1:0] w;
        bit full;
        bit acc;
        if (!n_rst) begin
            mq.delete();
            m_ptr  = '0;
            m_pix  = '0;
            m_addr = '0;
            return;
        end
        full = (mq.size() == WB);
        acc  = write_out_enable && (full || (img_done && mq.size() != 0));
        if (acc) begin
            w = '0;
            foreach (mq[i]) w[WB-1-i] = mq[i];
            m_pix  = w;
            m_addr = m_ptr;
            m_ptr  = (m_ptr == endpixel || img_done) ? '0 : m_ptr + 1;
            mq.delete();
        end
        if (out_en && mq.size() < WB) mq.push_back(edge_pixel);
    endtask

    task automatic cycle(input logic en, input logic px, input logic we);
        out_en = en;
        edge_pixel = px;
        write_out_enable = we;
        @(posedge clk);
        model_step();
        #1;
        out_en = 1'b0;
        write_out_enable = 1'b0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        img_done = 1'b0;
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0);
        do_reset();
        checks++;
        if (out_pixel !== 32'h0) begin errors++; $display("FAIL reset_pixel got=%h exp=%h", out_pixel, 32'h0); end
        checks++;
        if (write_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", write_addr, 32'h0); end
        checks++;
        if (out_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", out_empty); end
        checks++;
        if (out_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", out_full); end
    endtask

    task automatic test_full_word();
        endpixel = 32'd1000;
        img_done = 1'b0;
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (out_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", out_full); end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_pixel !== 32'hFFFFFFFF) begin errors++; $display("FAIL full_pixel got=%h exp=FFFFFFFF", out_pixel); end
        checks++;
        if (write_addr !== 32'h0) begin errors++; $display("FAIL full_addr got=%h exp=0", write_addr); end
        checks++;
        if (out_full !== 1'b0 || out_empty !== 1'b1) begin
            errors++; $display("FAIL full_flags_after got=full%b/empty%b exp=full0/empty1", out_full, out_empty);
        end
    endtask

    task automatic test_seq_addr();
        endpixel = 32'd31;
        img_done = 1'b0;
        do_reset();
        for (int k = 0; k < 18; k++) begin
            for (int i = 0; i < 32; i++) cycle(1'b1, logic'(k % 2), 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if (out_pixel !== ((k % 2) ? 32'hFFFFFFFF : 32'h0)) begin
                errors++; $display("FAIL seq_pixel k=%0d got=%h exp=%h", k, out_pixel, (k % 2) ? 32'hFFFFFFFF : 32'h0);
            end
            checks++;
            if (write_addr !== 32'(k)) begin errors++; $display("FAIL seq_addr k=%0d got=%0d exp=%0d", k, write_addr, k); end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr[4];
        exp_addr = '{32'd0, 32'd1, 32'd2, 32'd0};
        endpixel = 32'd2;
        img_done = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 32; i++) cycle(1'b1, logic'($urandom_range(0, 1)), 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if (write_addr !== exp_addr[k]) begin errors++; $display("FAIL wrap_addr k=%0d got=%0d exp=%0d", k, write_addr, exp_addr[k]); end
            checks++;
            if (out_pixel !== m_pix) begin errors++; $display("FAIL wrap_pixel k=%0d got=%h exp=%h", k, out_pixel, m_pix); end
        end
    endtask

    task automatic test_flush();
        endpixel = 32'd1000;
        do_reset();
        img_done = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_pixel !== 32'hF8000000) begin errors++; $display("FAIL flush_pixel got=%h exp=F8000000", out_pixel); end
        checks++;
        if (write_addr !== 32'h0) begin errors++; $display("FAIL flush_addr got=%0d exp=0", write_addr); end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_pixel !== 32'hE0000000 || write_addr !== 32'h0) begin
            errors++; $display("FAIL flush_second got=%h@%0d exp=E0000000@0", out_pixel, write_addr);
        end
        // An empty buffer must not flush even with img_done.
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_pixel !== 32'hE0000000 || out_empty !== 1'b1) begin
            errors++; $display("FAIL flush_empty got=%h empty=%b exp=E0000000 empty=1", out_pixel, out_empty);
        end
        img_done = 1'b0;
    endtask

    task automatic test_overflow_and_ignore();
        endpixel = 32'd1000;
        img_done = 1'b0;
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (out_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", out_full); end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_pixel !== 32'hFFFFFFFF) begin errors++; $display("FAIL ovf_pixel got=%h exp=FFFFFFFF", out_pixel); end
        for (int i = 0; i < 10; i++) cycle(1'b1, logic'($urandom_range(0, 1)), 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_pixel !== 32'hFFFFFFFF || write_addr !== 32'h0) begin
            errors++; $display("FAIL ignore_hold got=%h@%0d exp=FFFFFFFF@0", out_pixel, write_addr);
        end
        checks++;
        if (out_empty !== 1'b0 || out_full !== 1'b0) begin
            errors++; $display("FAIL ignore_flags got=empty%b/full%b exp=empty0/full0", out_empty, out_full);
        end
        for (int i = 0; i < 22; i++) cycle(1'b1, logic'($urandom_range(0, 1)), 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_pixel !== m_pix || write_addr !== 32'd1) begin
            errors++; $display("FAIL ignore_next got=%h@%0d exp=%h@1", out_pixel, write_addr, m_pix);
        end
    endtask

    task automatic test_back_to_back();
        logic [WB-1:0] first_word;
        endpixel = 32'd1000;
        img_done = 1'b0;
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, logic'($urandom_range(0, 1)), 1'b0);
        first_word = m_pix;
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (out_pixel !== m_pix || m_pix === first_word && mq.size() != 1) begin
            errors++; $display("FAIL b2b_pixel got=%h exp=%h", out_pixel, m_pix);
        end
        checks++;
        if (out_empty !== 1'b0 || out_full !== 1'b0) begin
            errors++; $display("FAIL b2b_flags got=empty%b/full%b exp=empty0/full0", out_empty, out_full);
        end
        for (int i = 0; i < 31; i++) cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (out_full !== 1'b1) begin errors++; $display("FAIL b2b_refill got=%b exp=1", out_full); end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_pixel !== 32'h80000000 || write_addr !== 32'd1) begin
            errors++; $display("FAIL b2b_second got=%h@%0d exp=80000000@1", out_pixel, write_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        endpixel = 32'($urandom_range(0, 5));
        for (int c = 0; c < 3000; c++) begin
            n_rst = ($urandom_range(0, 499) != 0);
            img_done = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) endpixel = 32'($urandom_range(0, 5));
            cycle(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 3) == 0));
            checks++;
            if (out_pixel !== m_pix || write_addr !== m_addr ||
                out_empty !== (mq.size() == 0) || out_full !== (mq.size() == WB)) begin
                errors++;
                $display("FAIL random c=%0d got=%h@%0d e%b f%b exp=%h@%0d e%b f%b", c, out_pixel, write_addr,
                         out_empty, out_full, m_pix, m_addr, mq.size() == 0, mq.size() == WB);
            end
        end
        n_rst = 1'b1;
        img_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_seq_addr();
        test_wrap();
        test_flush();
        test_overflow_and_ignore();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
